// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_ctrl
//  Purpose  : Run controller for the on-board 6502 core. Holds the core in
//             reset, then generates a prescaled core clock for a bounded
//             number of half-periods. Supports pause, single-cycle step and
//             an optional address breakpoint. Latches the core debug byte
//             onto the LED bank on every falling core-clock toggle.
//  Options  : CPU_RUN_BREAKPOINT_EN - when defined, the address breakpoint
//             is active. When undefined, bp_en/bp_addr/addr_bus are ignored
//             and bp_hit stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
   parameter int RESET_HOLD = 100,  // CLK cycles of core reset before running
   parameter int RUN_HALF   = 520,  // cpu_clk toggles per run (even, >= 2)
   parameter int PRESCALE   = 1,    // CLK cycles per cpu_clk half-period
   parameter int CW         = 32    // counter width
) (
   input  logic          CLK,
   input  logic          R,
   input  logic          go,
   input  logic          pause,
   input  logic          step,
   input  logic          bp_en,
   input  logic [15:0]   bp_addr,
   input  logic [15:0]   addr_bus,
   input  logic [7:0]    op,
   output logic          cpu_clk,
   output logic          cpu_res,
   output logic [2:0]    state,
   output logic [CW-1:0] half_cnt,
   output logic          done,
   output logic          bp_hit,
   output logic [7:0]    led
);

   // ------------------------------------------------------------------
   // State encoding (values are visible on the state port)
   // ------------------------------------------------------------------
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_HOLD  = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_PAUSE = 3'd3;
   localparam logic [2:0] ST_STEP  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   // Terminal counts, sized to the counter width
   localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);
   localparam logic [CW-1:0] PRE_LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] HALF_END  = CW'(RUN_HALF);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [2:0]    state_q,    state_d;
   logic          cpu_clk_q,  cpu_clk_d;
   logic          cpu_res_q,  cpu_res_d;
   logic [CW-1:0] half_cnt_q, half_cnt_d;
   logic          done_q,     done_d;
   logic          bp_hit_q,   bp_hit_d;
   logic [7:0]    led_q,      led_d;
   logic [CW-1:0] pre_q,      pre_d;       // prescaler
   logic [CW-1:0] hold_q,     hold_d;      // reset-hold counter
   logic          step_cnt_q, step_cnt_d;  // toggles already issued in STEP
   logic          first_q,    first_d;     // next RUN tick is the first after PAUSE
   logic          arm_q,      arm_d;       // pause seen high while in PAUSE

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic          in_clocked;  // RUN or STEP: prescaler is running
   logic          tick;        // prescaler terminal count this cycle
   logic          toggle;      // issue one cpu_clk half-period this cycle
   logic [CW-1:0] half_next;   // half_cnt after a toggle
   logic          bp_match;    // breakpoint address match

`ifdef CPU_RUN_BREAKPOINT_EN
   assign bp_match = bp_en && (addr_bus == bp_addr);
`else
   // Breakpoint compiled out: inputs stay on the port list but the match
   // is forced low so rule (b) can never fire.
   assign bp_match = 1'b0 & bp_en & (addr_bus == bp_addr);
`endif

   assign in_clocked = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign tick       = in_clocked && (pre_q == PRE_LAST);
   assign half_next  = half_cnt_q + CNT_ONE;

   // Next-state logic for the controller FSM, counters and output registers
   always_comb begin
      state_d    = state_q;
      cpu_clk_d  = cpu_clk_q;
      cpu_res_d  = cpu_res_q;
      half_cnt_d = half_cnt_q;
      done_d     = done_q;
      bp_hit_d   = bp_hit_q;
      led_d      = led_q;
      hold_d     = hold_q;
      step_cnt_d = step_cnt_q;
      first_d    = first_q;
      arm_d      = arm_q;
      toggle     = 1'b0;

      // Prescaler: free-runs in RUN/STEP, wraps on tick, and sits at zero in
      // every other state so that entry to RUN or STEP always starts from 0.
      if (tick) begin
         pre_d = '0;
      end else if (in_clocked) begin
         pre_d = pre_q + CNT_ONE;
      end else begin
         pre_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (go) begin
               state_d = ST_HOLD;
               hold_d  = '0;
            end
         end

         ST_HOLD: begin
            cpu_res_d = 1'b1;
            cpu_clk_d = 1'b0;
            if (hold_q == HOLD_LAST) begin
               state_d = ST_RUN;
               first_d = 1'b0;
            end else begin
               hold_d = hold_q + CNT_ONE;
            end
         end

         ST_RUN: begin
            if (tick) begin
               // Any tick consumes the post-resume breakpoint exemption
               first_d = 1'b0;
               if (!cpu_clk_q && pause) begin
                  state_d = ST_PAUSE;
                  arm_d   = 1'b0;
               end else if (!cpu_clk_q && bp_match && !first_q) begin
                  state_d  = ST_PAUSE;
                  bp_hit_d = 1'b1;
                  arm_d    = 1'b0;
               end else begin
                  toggle = 1'b1;
               end
            end
         end

         ST_PAUSE: begin
            cpu_clk_d = 1'b0;
            // A breakpoint pause needs pause to be raised and released
            if (pause) begin
               arm_d = 1'b1;
            end
            if (step) begin
               state_d    = ST_STEP;
               step_cnt_d = 1'b0;
            end else if (!pause && (!bp_hit_q || arm_q)) begin
               state_d  = ST_RUN;
               bp_hit_d = 1'b0;
               first_d  = 1'b1;
            end
         end

         ST_STEP: begin
            // Exactly two toggles, pause and breakpoint not consulted
            if (tick) begin
               toggle = 1'b1;
               if (step_cnt_q) begin
                  state_d = ST_PAUSE;
                  arm_d   = 1'b0;
               end else begin
                  step_cnt_d = 1'b1;
               end
            end
         end

         ST_DONE: begin
            if (go) begin
               state_d    = ST_HOLD;
               hold_d     = '0;
               half_cnt_d = '0;
               done_d     = 1'b0;
               bp_hit_d   = 1'b0;
               cpu_res_d  = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Rule (c): toggle the core clock. Budget exhaustion overrides any
      // state chosen above; RUN_HALF is even so DONE always sees cpu_clk=0.
      if (toggle) begin
         cpu_clk_d  = ~cpu_clk_q;
         half_cnt_d = half_next;
         cpu_res_d  = 1'b0;
         if (cpu_clk_q) begin
            led_d = op;
         end
         if (half_next == HALF_END) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end
      end
   end

   // State and output registers with synchronous active-high reset
   always_ff @(posedge CLK) begin
      if (R) begin
         state_q    <= ST_IDLE;
         cpu_clk_q  <= 1'b0;
         cpu_res_q  <= 1'b1;
         half_cnt_q <= '0;
         done_q     <= 1'b0;
         bp_hit_q   <= 1'b0;
         led_q      <= 8'h00;
         pre_q      <= '0;
         hold_q     <= '0;
         step_cnt_q <= 1'b0;
         first_q    <= 1'b0;
         arm_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cpu_clk_q  <= cpu_clk_d;
         cpu_res_q  <= cpu_res_d;
         half_cnt_q <= half_cnt_d;
         done_q     <= done_d;
         bp_hit_q   <= bp_hit_d;
         led_q      <= led_d;
         pre_q      <= pre_d;
         hold_q     <= hold_d;
         step_cnt_q <= step_cnt_d;
         first_q    <= first_d;
         arm_q      <= arm_d;
      end
   end

   assign cpu_clk  = cpu_clk_q;
   assign cpu_res  = cpu_res_q;
   assign state    = state_q;
   assign half_cnt = half_cnt_q;
   assign done     = done_q;
   assign bp_hit   = bp_hit_q;
   assign led      = led_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_run_ctrl
//  Purpose  : Directed self-checking bench for cpu_run_ctrl with
//             RESET_HOLD=4, RUN_HALF=8, PRESCALE=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

   localparam int CW = 32;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_HOLD  = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_PAUSE = 3'd3;
   localparam logic [2:0] ST_STEP  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   logic          CLK;
   logic          R;
   logic          go;
   logic          pause;
   logic          step;
   logic          bp_en;
   logic [15:0]   bp_addr;
   logic [15:0]   addr_bus;
   logic [7:0]    op;
   logic          cpu_clk;
   logic          cpu_res;
   logic [2:0]    state;
   logic [CW-1:0] half_cnt;
   logic          done;
   logic          bp_hit;
   logic [7:0]    led;

   int total;
   int bad;

   cpu_run_ctrl #(
      .RESET_HOLD (4),
      .RUN_HALF   (8),
      .PRESCALE   (2),
      .CW         (CW)
   ) dut (
      .CLK      (CLK),
      .R        (R),
      .go       (go),
      .pause    (pause),
      .step     (step),
      .bp_en    (bp_en),
      .bp_addr  (bp_addr),
      .addr_bus (addr_bus),
      .op       (op),
      .cpu_clk  (cpu_clk),
      .cpu_res  (cpu_res),
      .state    (state),
      .half_cnt (half_cnt),
      .done     (done),
      .bp_hit   (bp_hit),
      .led      (led)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance one clock; sample point is 1 time unit after the edge
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // Bounded wait for half_cnt to reach a value
   task automatic wait_half(input logic [CW-1:0] target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (half_cnt == target) begin
            ok = 1'b1;
            return;
         end
         cyc();
      end
      ok = (half_cnt == target);
   endtask

   // Bounded wait for a given state
   task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (state == target) begin
            ok = 1'b1;
            return;
         end
         cyc();
      end
      ok = (state == target);
   endtask

   // Pulse go for one edge
   task automatic pulse_go();
      go = 1'b1;
      cyc();
      go = 1'b0;
   endtask

   task automatic test_reset();
      R = 1'b1;
      repeat (3) cyc();
      total++; if (state !== ST_IDLE) begin bad++; $display("FAIL reset_state got %0d want %0d", state, ST_IDLE); end
      total++; if (cpu_clk !== 1'b0) begin bad++; $display("FAIL reset_cpu_clk got %b want 0", cpu_clk); end
      total++; if (cpu_res !== 1'b1) begin bad++; $display("FAIL reset_cpu_res got %b want 1", cpu_res); end
      total++; if (half_cnt !== 32'd0) begin bad++; $display("FAIL reset_half_cnt got %0d want 0", half_cnt); end
      total++; if (done !== 1'b0 || bp_hit !== 1'b0) begin bad++; $display("FAIL reset_flags got done=%b bp_hit=%b want 0 0", done, bp_hit); end
      total++; if (led !== 8'h00) begin bad++; $display("FAIL reset_led got %h want 00", led); end
      R = 1'b0;
      cyc();
      total++; if (state !== ST_IDLE) begin bad++; $display("FAIL idle_no_go got %0d want %0d", state, ST_IDLE); end
   endtask

   // Exact-timing plain run: 4 HOLD cycles, then 8 toggles every 2 cycles
   task automatic test_plain_run();
      op = 8'h11;
      pulse_go();
      for (int i = 0; i < 4; i++) begin
         total++; if (state !== ST_HOLD || cpu_res !== 1'b1) begin bad++; $display("FAIL hold_c%0d got state=%0d res=%b want 1 1", i, state, cpu_res); end
         cyc();
      end
      total++; if (state !== ST_RUN || cpu_res !== 1'b1 || cpu_clk !== 1'b0) begin bad++; $display("FAIL run_entry got state=%0d res=%b clk=%b want 2 1 0", state, cpu_res, cpu_clk); end
      for (int k = 1; k <= 8; k++) begin
         cyc();
         total++; if (half_cnt !== 32'(k - 1)) begin bad++; $display("FAIL plain_gap%0d half_cnt got %0d want %0d", k, half_cnt, k - 1); end
         cyc();
         total++; if (half_cnt !== 32'(k) || cpu_clk !== logic'(k % 2)) begin bad++; $display("FAIL plain_t%0d got half=%0d clk=%b want %0d %0d", k, half_cnt, cpu_clk, k, k % 2); end
         total++; if (cpu_res !== 1'b0) begin bad++; $display("FAIL plain_res_t%0d got %b want 0", k, cpu_res); end
      end
      total++; if (state !== ST_DONE || done !== 1'b1 || cpu_clk !== 1'b0) begin bad++; $display("FAIL plain_done got state=%0d done=%b clk=%b want 5 1 0", state, done, cpu_clk); end
      total++; if (led !== 8'h11) begin bad++; $display("FAIL plain_led got %h want 11", led); end
      cyc();
      total++; if (state !== ST_DONE || half_cnt !== 32'd8) begin bad++; $display("FAIL done_stays got state=%0d half=%0d want 5 8", state, half_cnt); end
   endtask

   // Restart from DONE and check the LED latch on falling toggles only
   task automatic test_led();
      bit ok;
      pulse_go();
      total++; if (state !== ST_HOLD || half_cnt !== 32'd0 || done !== 1'b0 || cpu_res !== 1'b1) begin bad++; $display("FAIL restart got state=%0d half=%0d done=%b res=%b want 1 0 0 1", state, half_cnt, done, cpu_res); end
      total++; if (led !== 8'h11) begin bad++; $display("FAIL led_retained got %h want 11", led); end
      wait_half(1, 40, ok);
      total++; if (!ok) begin bad++; $display("FAIL led_wait1 timeout half=%0d want 1", half_cnt); end
      op = 8'hA5;
      wait_half(2, 10, ok);
      total++; if (!ok || led !== 8'hA5) begin bad++; $display("FAIL led_t2 got %h want a5", led); end
      op = 8'h3C;
      wait_half(3, 10, ok);
      total++; if (!ok || led !== 8'hA5) begin bad++; $display("FAIL led_t3 got %h want a5", led); end
      wait_half(4, 10, ok);
      total++; if (!ok || led !== 8'h3C) begin bad++; $display("FAIL led_t4 got %h want 3c", led); end
      wait_state(ST_DONE, 40, ok);
      total++; if (!ok) begin bad++; $display("FAIL led_done timeout state=%0d want 5", state); end
   endtask

   task automatic test_pause_step();
      bit ok;
      int n;
      pulse_go();
      wait_half(1, 40, ok);
      // step is ignored outside PAUSE
      step = 1'b1;
      cyc();
      step = 1'b0;
      total++; if (state !== ST_RUN) begin bad++; $display("FAIL step_in_run got %0d want %0d", state, ST_RUN); end
      wait_half(2, 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL ps_wait2 timeout half=%0d want 2", half_cnt); end
      pause = 1'b1;
      wait_state(ST_PAUSE, 10, ok);
      total++; if (!ok || half_cnt !== 32'd2 || cpu_clk !== 1'b0) begin bad++; $display("FAIL pause_entry got state=%0d half=%0d clk=%b want 3 2 0", state, half_cnt, cpu_clk); end
      repeat (3) cyc();
      total++; if (state !== ST_PAUSE || half_cnt !== 32'd2) begin bad++; $display("FAIL pause_hold got state=%0d half=%0d want 3 2", state, half_cnt); end
      step = 1'b1;
      cyc();
      step = 1'b0;
      total++; if (state !== ST_STEP) begin bad++; $display("FAIL step_entry got %0d want %0d", state, ST_STEP); end
      n = 0;
      while (state !== ST_PAUSE && n < 20) begin
         cyc();
         n++;
      end
      total++; if (n != 4 || half_cnt !== 32'd4 || cpu_clk !== 1'b0) begin bad++; $display("FAIL step_two got cycles=%0d half=%0d clk=%b want 4 4 0", n, half_cnt, cpu_clk); end
      pause = 1'b0;
      cyc();
      total++; if (state !== ST_RUN || bp_hit !== 1'b0) begin bad++; $display("FAIL resume got state=%0d bp_hit=%b want 2 0", state, bp_hit); end
      wait_state(ST_DONE, 40, ok);
      total++; if (!ok || half_cnt !== 32'd8 || cpu_clk !== 1'b0) begin bad++; $display("FAIL ps_done got state=%0d half=%0d clk=%b want 5 8 0", state, half_cnt, cpu_clk); end
   endtask

`ifdef CPU_RUN_BREAKPOINT_EN
   task automatic test_breakpoint();
      bit ok;
      bp_en    = 1'b1;
      bp_addr  = 16'hFFFC;
      addr_bus = 16'h0000;
      pulse_go();
      wait_half(4, 40, ok);
      addr_bus = 16'hFFFC;
      wait_state(ST_PAUSE, 10, ok);
      total++; if (!ok || half_cnt !== 32'd4 || bp_hit !== 1'b1 || cpu_clk !== 1'b0) begin bad++; $display("FAIL bp_entry got state=%0d half=%0d bp_hit=%b want 3 4 1", state, half_cnt, bp_hit); end
      repeat (3) cyc();
      total++; if (state !== ST_PAUSE || bp_hit !== 1'b1) begin bad++; $display("FAIL bp_hold got state=%0d bp_hit=%b want 3 1", state, bp_hit); end
      pause = 1'b1;
      cyc();
      pause = 1'b0;
      cyc();
      total++; if (state !== ST_RUN || bp_hit !== 1'b0) begin bad++; $display("FAIL bp_resume got state=%0d bp_hit=%b want 2 0", state, bp_hit); end
      wait_half(5, 4, ok);
      total++; if (!ok || state !== ST_RUN) begin bad++; $display("FAIL bp_first_tick got half=%0d state=%0d want 5 2", half_cnt, state); end
      addr_bus = 16'h0000;
      wait_state(ST_DONE, 40, ok);
      total++; if (!ok || half_cnt !== 32'd8) begin bad++; $display("FAIL bp_done got state=%0d half=%0d want 5 8", state, half_cnt); end
      bp_en = 1'b0;
   endtask
`else
   task automatic test_bp_compiled_out();
      bit ok;
      bit saw_pause;
      bit saw_bp;
      bp_en    = 1'b1;
      bp_addr  = 16'hFFFC;
      addr_bus = 16'h0000;
      pulse_go();
      wait_half(4, 40, ok);
      addr_bus  = 16'hFFFC;
      saw_pause = 1'b0;
      saw_bp    = 1'b0;
      for (int i = 0; i < 40 && state !== ST_DONE; i++) begin
         cyc();
         if (state === ST_PAUSE) saw_pause = 1'b1;
         if (bp_hit !== 1'b0)    saw_bp    = 1'b1;
      end
      total++; if (saw_pause || saw_bp) begin bad++; $display("FAIL nobp_pause got pause=%b bp_hit=%b want 0 0", saw_pause, saw_bp); end
      total++; if (state !== ST_DONE || half_cnt !== 32'd8) begin bad++; $display("FAIL nobp_done got state=%0d half=%0d want 5 8", state, half_cnt); end
      addr_bus = 16'h0000;
      bp_en    = 1'b0;
   endtask
`endif

   task automatic test_reset_midrun();
      bit ok;
      pulse_go();
      wait_half(3, 40, ok);
      pulse_go();
      total++; if (state !== ST_RUN || half_cnt !== 32'd3) begin bad++; $display("FAIL go_in_run got state=%0d half=%0d want 2 3", state, half_cnt); end
      wait_half(5, 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL mid_wait5 timeout half=%0d want 5", half_cnt); end
      R = 1'b1;
      cyc();
      R = 1'b0;
      total++; if (state !== ST_IDLE || cpu_clk !== 1'b0 || cpu_res !== 1'b1 || half_cnt !== 32'd0) begin bad++; $display("FAIL mid_reset got state=%0d clk=%b res=%b half=%0d want 0 0 1 0", state, cpu_clk, cpu_res, half_cnt); end
      total++; if (led !== 8'h00 || done !== 1'b0) begin bad++; $display("FAIL mid_reset_regs got led=%h done=%b want 00 0", led, done); end
      pulse_go();
      total++; if (state !== ST_HOLD) begin bad++; $display("FAIL idle_go got %0d want %0d", state, ST_HOLD); end
      wait_state(ST_DONE, 40, ok);
      total++; if (!ok || half_cnt !== 32'd8 || cpu_clk !== 1'b0) begin bad++; $display("FAIL mid_done got state=%0d half=%0d want 5 8", state, half_cnt); end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      R        = 1'b1;
      go       = 1'b0;
      pause    = 1'b0;
      step     = 1'b0;
      bp_en    = 1'b0;
      bp_addr  = 16'h0000;
      addr_bus = 16'h0000;
      op       = 8'h00;
      #1;
      test_reset();
      test_plain_run();
      test_led();
      test_pause_step();
`ifdef CPU_RUN_BREAKPOINT_EN
      test_breakpoint();
`else
      test_bp_compiled_out();
`endif
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the 6502 core on the board. It holds the core in reset for a fixed number of board clocks, then generates the core clock as a register toggled by a prescaler. It runs for a bounded number of half-periods and supports pause, single-cycle step and an optional address breakpoint. It also latches the core's `op` byte on each core-clock falling edge for the LED bank.

## Interface
- `RESET_HOLD`, 100: CLK cycles `cpu_res` is held high in HOLD before the first toggle (≥1).
- `RUN_HALF`, 520: `cpu_clk` toggles per run. Must be even and ≥2.
- `PRESCALE`, 1: CLK cycles per `cpu_clk` half-period (≥1).
- `CW`, 32: width of `half_cnt` and internal counters.
- `CLK`  in  1  board clock; the only clock.
- `R`  in  1  synchronous, active-high reset.
- `go`  in  1  start pulse; honoured in IDLE and DONE only.
- `pause`  in  1  level; requests a halt with `cpu_clk` low.
- `step`  in  1  pulse; honoured in PAUSE only.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  16  breakpoint address.
- `addr_bus`  in  16  core address bus.
- `op`  in  8  core debug byte.
- `cpu_clk`  out  1  core clock (register).
- `cpu_res`  out  1  core reset, active high.
- `state`  out  3  IDLE=0, HOLD=1, RUN=2, PAUSE=3, STEP=4, DONE=5.
- `half_cnt`  out  CW  toggles issued in the current run.
- `done`  out  1  high in DONE.
- `bp_hit`  out  1  sticky; set on breakpoint entry to PAUSE.
- `led`  out  8  `op` latched at the last falling toggle.

## Operation
- On reset (`R`=1): state IDLE, `cpu_clk`=0, `cpu_res`=1, `half_cnt`=0, `done`=0, `bp_hit`=0, `led`=0, prescaler=0. `R` overrides every other input.
- **Tick**: prescaler reaches PRESCALE−1 in RUN or STEP. The prescaler then wraps to 0. The prescaler clears on entry to RUN or STEP.
- **IDLE**: on `go`, go to HOLD and clear the hold counter.
- **DONE**: on `go`, clear `half_cnt`, `done` and `bp_hit`, set `cpu_res`=1, and go to HOLD. `led` is retained.
- **HOLD**: `cpu_res`=1 and `cpu_clk`=0. After RESET_HOLD cycles, go to RUN.
- **RUN**, at each tick, evaluated in this priority order:
  - (a) `cpu_clk`=0 and `pause`=1: go to PAUSE and do not toggle.
  - (b) `cpu_clk`=0, breakpoint match, and this is not the first tick since leaving PAUSE: go to PAUSE, set `bp_hit`, and do not toggle.
  - (c) otherwise:
    - Toggle `cpu_clk`, `half_cnt`++, `cpu_res`<=0. `cpu_res` falls with the first toggle.
    - On a 1→0 toggle, `led`<=`op`.
    - If the new `half_cnt`==RUN_HALF, go to DONE.
- **PAUSE**: `cpu_clk` is held at 0.
  - `step`=1: go to STEP. `step` has priority over resume.
  - Otherwise, `pause`=0 while `bp_hit` is clear, or a rising edge of `pause` then release: go to RUN.
  - Simplified rule: resume happens when `pause`=0 and `step`=0, and `bp_hit` is either clear or was cleared by that resume. Resume clears `bp_hit`.
- **STEP**: issue exactly two toggles with rule (c), ignoring pause and breakpoint. Then go back to PAUSE, or to DONE if the budget is reached.
- **Breakpoint match**: `bp_en` && `addr_bus`==`bp_addr`, sampled on the tick edge.
- **Ignored inputs**: `go` in HOLD, RUN, PAUSE and STEP; `step` outside PAUSE.
- **Budget**: `half_cnt` never exceeds RUN_HALF, and DONE always leaves `cpu_clk`=0.

## Timing
- `go` sampled at edge N: HOLD from N+1, RUN from N+1+RESET_HOLD.
- First toggle occurs PRESCALE cycles after entering RUN.
- A full run with no pauses takes RESET_HOLD + RUN_HALF·PRESCALE CLK cycles from HOLD entry to DONE entry.
- `cpu_clk` period is 2·PRESCALE CLK cycles. Duty is 50% except across pauses.
- `led` updates on the same edge as the falling toggle.
- `pause` asserted while `cpu_clk`=1: takes effect at the second tick, after the falling toggle. The worst case is 2·PRESCALE cycles.
- All outputs are registered. `done`, `state` and `bp_hit` change on the transition edge.

## Configuration
- `CPU_RUN_BREAKPOINT_EN` defined: breakpoint logic is present as described.
- Not defined: `bp_en`, `bp_addr` and `addr_bus` are ignored, rule (b) never fires, and `bp_hit` is constant 0. Ports remain.

## Test plan
Parameters for all scenarios: RESET_HOLD=4, RUN_HALF=8, PRESCALE=2.
- **Reset and plain run**: `R` high 3 cycles, then `go` pulse. `cpu_res`=1 for 4 cycles in HOLD and falls with the first toggle. Expect 8 toggles at 2-cycle spacing, then `done`=1, `half_cnt`=8, `cpu_clk`=0.
- **LED latch**: drive `op`=8'hA5 before the 2nd toggle and 8'h3C before the 4th. `led`=A5 after toggle 2 and 3C after toggle 4.
- **Pause and step**: assert `pause` after toggle 2. Expect PAUSE with `half_cnt`=2. Pulse `step`: exactly 2 toggles, then PAUSE with `half_cnt`=4. Deassert `pause`: RUN resumes and reaches DONE at 8.
- **Breakpoint** (macro defined): `bp_en`=1, `bp_addr`=16'hFFFC, `addr_bus`=FFFC from toggle 4. Expect PAUSE with `half_cnt`=4 and `bp_hit`=1. Resume: `bp_hit`=0, the next toggle is not blocked, and the run reaches DONE.
- **Breakpoint compiled out**: same stimulus with the macro undefined. No pause, and `bp_hit` stays 0.
- **Reset mid-run and restart**: assert `R` during RUN at `half_cnt`=5. Next cycle: IDLE, `cpu_clk`=0, `cpu_res`=1, `half_cnt`=0. `go` in RUN is ignored. `go` in DONE restarts at HOLD.
